// File: rtl/game_tick_scheduler.sv
// Move-rate prescaler for the snake game: wraps at a speed-dependent max and raises
// a move tick to game logic over a req/ack handshake, flagging ticks the consumer missed.
module game_tick_scheduler #(
  parameter int               WIDTH    = 20,
  parameter int               LEVELS   = 8,
  parameter logic [WIDTH-1:0] BASE_MAX = 20'd999999,
  parameter logic [WIDTH-1:0] STEP     = 20'd100000,
  parameter logic [WIDTH-1:0] MIN_MAX  = 20'd199999
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      speed_up,
  input  logic                      speed_reset,
  input  logic                      tick_ack,
  output logic                      tick_req,
  output logic                      overrun,
  output logic [$clog2(LEVELS)-1:0] level,
  output logic [WIDTH-1:0]          count,
  output logic [1:0]                state
);

  localparam int               LW        = $clog2(LEVELS);
  localparam int               EW        = WIDTH + 4;
  localparam logic [LW-1:0]    LEVEL_TOP = LW'(LEVELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  state_t           state_q;
  logic [EW-1:0]    step_prod;
  logic [EW-1:0]    base_ext;
  logic [EW-1:0]    min_ext;
  logic [EW-1:0]    diff;
  logic [WIDTH-1:0] max_cur;

  // Widened arithmetic so level*STEP can exceed BASE_MAX without wrapping around.
  always_comb begin
    step_prod = EW'(level) * EW'(STEP);
    base_ext  = EW'(BASE_MAX);
    min_ext   = EW'(MIN_MAX);
    diff      = (step_prod >= base_ext) ? '0 : base_ext - step_prod;
    max_cur   = (diff < min_ext) ? MIN_MAX : diff[WIDTH-1:0];
  end

  assign state = state_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      level    <= '0;
      tick_req <= 1'b0;
      overrun  <= 1'b0;
    end else if (state_q == ST_BAD) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      tick_req <= 1'b0;
    end else if (start) begin
      state_q  <= ST_RUN;
      count    <= '0;
      tick_req <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (tick_req && tick_ack) begin
        tick_req <= 1'b0;
      end
      // A pulse consumed at a higher priority suppresses the lower ones this cycle.
      if (pause && state_q != ST_IDLE) begin
        state_q <= (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
      end else if (speed_reset) begin
        level <= '0;
        count <= '0;
      end else if (speed_up) begin
        if (level != LEVEL_TOP) begin
          level <= level + LW'(1);
        end
        count <= '0;
      end else if (state_q == ST_RUN) begin
        if (count == max_cur) begin
          count    <= '0;
          tick_req <= 1'b1;
          if (tick_req && !tick_ack) begin
            overrun <= 1'b1;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: stimulus queues expected snapshots and tick
// edges; a monitor compares them against the DUT as each clock edge settles.
module tb_game_tick_scheduler;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        pause;
  logic        speed_up;
  logic        speed_reset;
  logic        tick_ack;
  logic        tick_req;
  logic        overrun;
  logic [1:0]  level;
  logic [19:0] count;
  logic [1:0]  state;

  typedef struct {
    int          edge_n;
    string       tag;
    logic [1:0]  st;
    logic [19:0] cnt;
    logic [1:0]  lvl;
    logic        req;
    logic        ovr;
  } snap_t;

  snap_t snap_q[$];
  int    tick_q[$];
  int    edge_cnt   = 0;
  int    compared   = 0;
  int    mismatched = 0;
  bit    tick_en    = 1'b0;
  logic  prev_req   = 1'b0;

  game_tick_scheduler #(
    .WIDTH   (20),
    .LEVELS  (4),
    .BASE_MAX(20'd9),
    .STEP    (20'd2),
    .MIN_MAX (20'd3)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .pause      (pause),
    .speed_up   (speed_up),
    .speed_reset(speed_reset),
    .tick_ack   (tick_ack),
    .tick_req   (tick_req),
    .overrun    (overrun),
    .level      (level),
    .count      (count),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int nxt();
    return edge_cnt + 1;
  endfunction

  task automatic expectSnap(input int e, input string tag, input logic [1:0] st,
                            input logic [19:0] cnt, input logic [1:0] lvl,
                            input logic req, input logic ovr);
    snap_t s;
    s.edge_n = e; s.tag = tag; s.st = st; s.cnt = cnt; s.lvl = lvl; s.req = req; s.ovr = ovr;
    snap_q.push_back(s);
  endtask

  // Drive one cycle of pulses, sampled by the next rising edge, then return to idle inputs.
  task automatic applyStimulus(input logic st, input logic pa, input logic su,
                               input logic sr, input logic ak);
    start = st; pause = pa; speed_up = su; speed_reset = sr; tick_ack = ak;
    @(negedge clock);
    start = 1'b0; pause = 1'b0; speed_up = 1'b0; speed_reset = 1'b0; tick_ack = 1'b0;
  endtask

  task automatic waitEdge(input int target);
    while (edge_cnt < target) @(negedge clock);
  endtask

  // Monitor: settles 1 time unit after each rising edge, then checks due snapshots and tick rises.
  always @(posedge clock) begin
    #1;
    edge_cnt++;
    for (int i = snap_q.size() - 1; i >= 0; i--) begin
      if (snap_q[i].edge_n == edge_cnt) begin
        checkOutput({snap_q[i].tag, ".state"},    32'(state),    32'(snap_q[i].st));
        checkOutput({snap_q[i].tag, ".count"},    32'(count),    32'(snap_q[i].cnt));
        checkOutput({snap_q[i].tag, ".level"},    32'(level),    32'(snap_q[i].lvl));
        checkOutput({snap_q[i].tag, ".tick_req"}, 32'(tick_req), 32'(snap_q[i].req));
        checkOutput({snap_q[i].tag, ".overrun"},  32'(overrun),  32'(snap_q[i].ovr));
        snap_q.delete(i);
      end else if (snap_q[i].edge_n < edge_cnt) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got no sample, expected one at edge %0d", snap_q[i].tag, snap_q[i].edge_n);
        snap_q.delete(i);
      end
    end
    if (tick_en && tick_req === 1'b1 && prev_req !== 1'b1) begin
      if (tick_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL tick_unexpected: got rise at edge %0d, expected none", edge_cnt);
      end else begin
        checkOutput("tick_edge", 32'(edge_cnt), 32'(tick_q.pop_front()));
      end
    end
    prev_req = tick_req;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int e;
    int t;
    resetn = 1'b0; start = 1'b0; pause = 1'b0; speed_up = 1'b0; speed_reset = 1'b0; tick_ack = 1'b0;

    // Power-on reset, then IDLE holds count at 0 and ignores pause.
    @(negedge clock);
    e = nxt();
    expectSnap(e, "reset", 2'b00, 20'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    e = nxt();
    expectSnap(e,     "idle_pause", 2'b00, 20'd0, 2'd0, 1'b0, 1'b0);
    expectSnap(e + 1, "idle_hold",  2'b00, 20'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    $display("[TB] basic tick period with acks");

    tick_en = 1'b1;
    s = nxt();
    expectSnap(s,      "t2_start",   2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    expectSnap(s + 9,  "t2_prewrap", 2'b01, 20'd9, 2'd0, 1'b0, 1'b0);
    expectSnap(s + 10, "t2_wrap",    2'b01, 20'd0, 2'd0, 1'b1, 1'b0);
    tick_q.push_back(s + 10); tick_q.push_back(s + 20); tick_q.push_back(s + 30);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      waitEdge(s + 10 * k);
      e = nxt();
      expectSnap(e, "t2_ack", 2'b01, 20'd1, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    $display("[TB] speed_up saturation");

    s = nxt();
    expectSnap(s, "t3_start", 2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      e = nxt();
      expectSnap(e, "t3_speed_up", 2'b01, 20'd0, (i > 3) ? 2'd3 : 2'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick_q.push_back(s + 9); tick_q.push_back(s + 13); tick_q.push_back(s + 17);
    for (int k = 0; k < 3; k++) begin
      waitEdge(s + 9 + 4 * k);
      e = nxt();
      expectSnap(e, "t3_ack", 2'b01, 20'd1, 2'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    e = nxt();
    expectSnap(e, "t3_speed_reset", 2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("[TB] overrun without ack");

    s = nxt();
    expectSnap(s,      "t4_start",   2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    expectSnap(s + 10, "t4_tick",    2'b01, 20'd0, 2'd0, 1'b1, 1'b0);
    expectSnap(s + 19, "t4_prewrap", 2'b01, 20'd9, 2'd0, 1'b1, 1'b0);
    expectSnap(s + 20, "t4_overrun", 2'b01, 20'd0, 2'd0, 1'b1, 1'b1);
    expectSnap(s + 21, "t4_sticky",  2'b01, 20'd1, 2'd0, 1'b1, 1'b1);
    tick_q.push_back(s + 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitEdge(s + 22);
    e = nxt();
    expectSnap(e, "t4_restart", 2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_en = 1'b0;
    $display("[TB] pause and resume");

    s = nxt();
    expectSnap(s, "t5_start", 2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitEdge(s + 4);
    e = nxt();
    expectSnap(e,     "t5_paused",     2'b10, 20'd4, 2'd0, 1'b0, 1'b0);
    expectSnap(e + 3, "t5_paused_mid", 2'b10, 20'd4, 2'd0, 1'b0, 1'b0);
    expectSnap(e + 6, "t5_paused_end", 2'b10, 20'd4, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdge(s + 11);
    e = nxt();
    expectSnap(e,     "t5_resume",  2'b01, 20'd4, 2'd0, 1'b0, 1'b0);
    expectSnap(e + 1, "t5_counting", 2'b01, 20'd5, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdge(e + 1);
    $display("[TB] ack on wrap cycle and start/pause priority");

    tick_en = 1'b1;
    s = nxt();
    expectSnap(s,      "t6_start",   2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    expectSnap(s + 19, "t6_prewrap", 2'b01, 20'd9, 2'd0, 1'b1, 1'b0);
    tick_q.push_back(s + 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitEdge(s + 19);
    e = nxt();
    expectSnap(e,     "t6_ack_wrap", 2'b01, 20'd0, 2'd0, 1'b1, 1'b0);
    expectSnap(e + 1, "t6_after",    2'b01, 20'd1, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitEdge(s + 21);
    e = nxt();
    expectSnap(e,     "t6_start_pause", 2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    expectSnap(e + 1, "t6_still_run",   2'b01, 20'd1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdge(e + 1);
    tick_en = 1'b0;
    $display("[TB] reset from RUN with pending tick");

    s = nxt();
    expectSnap(s, "t1_start", 2'b01, 20'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = nxt();
    expectSnap(e, "t1_level1", 2'b01, 20'd0, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t = nxt();
    expectSnap(t,     "t1_level2", 2'b01, 20'd0, 2'd2, 1'b0, 1'b0);
    expectSnap(t + 6, "t1_wrap",   2'b01, 20'd0, 2'd2, 1'b1, 1'b0);
    expectSnap(t + 7, "t1_busy",   2'b01, 20'd1, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    waitEdge(t + 7);
    e = nxt();
    expectSnap(e,     "t1_reset",      2'b00, 20'd0, 2'd0, 1'b0, 1'b0);
    expectSnap(e + 1, "t1_after_reset", 2'b00, 20'd0, 2'd0, 1'b0, 1'b0);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    waitEdge(e + 3);

    while (snap_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got no sample, expected one at edge %0d", snap_q[0].tag, snap_q[0].edge_n);
      void'(snap_q.pop_front());
    end
    while (tick_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL tick_missing: got no rise, expected one at edge %0d", tick_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
